// File: rtl/rotate_arbiter.sv
// Round-robin front end for one shared 32-bit rotator. It serves one request at a time
// from two requesters and returns each tagged result over a valid/ready channel.
module rotate_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_data,
    input  logic [4:0]  i_req0_shift,
    input  logic        i_req0_left,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_data,
    input  logic [4:0]  i_req1_shift,
    input  logic        i_req1_left,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_out_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_prio;

    logic [31:0] r_data_p0;
    logic [4:0]  r_shift_p0;
    logic        r_left_p0;
    logic        r_id_p0;

    logic [31:0] r_data_p1;
    logic        r_id_p1;
    logic        r_vld_p1;

    logic        w_both;
    logic        w_grant_id;
    logic        w_grant_vld;
    logic [31:0] w_sel_data;
    logic [4:0]  w_sel_shift;
    logic        w_sel_left;
    logic [31:0] w_rot;

    // A right rotate by s is a left rotate by (32 - s) mod 32, so one left
    // barrel shifter over the doubled word serves both directions.
    function automatic logic [31:0] rotate32(input logic [31:0] din,
                                             input logic [4:0]  amt,
                                             input logic        left);
        logic [4:0]  l_amt;
        logic [63:0] l_wide;
        l_amt  = left ? amt : (5'd0 - amt);
        l_wide = {din, din} << l_amt;
        return l_wide[63:32];
    endfunction

    // Arbitration: a lone requester wins outright, a tie goes to r_prio.
    assign w_both      = i_req0_valid & i_req1_valid;
    assign w_grant_id  = w_both ? r_prio : i_req1_valid;
    assign w_grant_vld = i_rst_n & (r_state == S_IDLE) & (i_req0_valid | i_req1_valid);

    assign o_req0_ready = w_grant_vld & ~w_grant_id;
    assign o_req1_ready = w_grant_vld &  w_grant_id;

    assign w_sel_data  = w_grant_id ? i_req1_data  : i_req0_data;
    assign w_sel_shift = w_grant_id ? i_req1_shift : i_req0_shift;
    assign w_sel_left  = w_grant_id ? i_req1_left  : i_req0_left;

    // The single shared rotator instance, fed only from the operand registers.
    assign w_rot = rotate32(r_data_p0, r_shift_p0, r_left_p0);

    assign o_out_valid = r_vld_p1;
    assign o_out_data  = r_data_p1;
    assign o_out_id    = r_id_p1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_data_p0  <= '0;
            r_shift_p0 <= '0;
            r_left_p0  <= 1'b0;
            r_id_p0    <= 1'b0;
            r_data_p1  <= '0;
            r_id_p1    <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            case (r_state)
                // Stage p0: operand capture on the request handshake
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_data_p0  <= w_sel_data;
                        r_shift_p0 <= w_sel_shift;
                        r_left_p0  <= w_sel_left;
                        r_id_p0    <= w_grant_id;
                        r_prio     <= ~w_grant_id;
                        r_state    <= S_EXEC;
                    end
                end
                // Stage p1: rotator result registered into the response slot
                S_EXEC: begin
                    r_data_p1 <= w_rot;
                    r_id_p1   <= r_id_p0;
                    r_vld_p1  <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (i_out_ready) begin
                        r_vld_p1 <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_vld_p1 <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_arbiter.sv
// Bench for rotate_arbiter: directed vector table, hand-written reset and
// backpressure sequences, then random traffic against a bit-level reference model.
module tb_rotate_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_left;
    logic [31:0] req0_data;
    logic [4:0]  req0_shift;
    logic        req1_valid, req1_ready, req1_left;
    logic [31:0] req1_data;
    logic [4:0]  req1_shift;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic [4:0]  s0;
        logic        l0;
        logic        v1;
        logic [31:0] d1;
        logic [4:0]  s1;
        logic        l1;
        logic        exp_id;
        logic [31:0] exp_data;
        int          stall;
    } vec_t;

    rotate_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_data  (req0_data),
        .i_req0_shift (req0_shift),
        .i_req0_left  (req0_left),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_data  (req1_data),
        .i_req1_shift (req1_shift),
        .i_req1_left  (req1_left),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_id     (out_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rotation: place each source bit at its destination index.
    function automatic logic [31:0] ref_rot(input logic [31:0] d, input int s, input bit left);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (left) r[(i + s) % 32] = d[i];
            else      r[(i - s + 32) % 32] = d[i];
        end
        return r;
    endfunction

    // One full transaction: present inputs, expect an immediate grant, check the
    // EXEC cycle, then the response held for (stall+1) cycles before transfer.
    task automatic run_txn(input vec_t v, input string tag);
        int k;
        @(negedge clk);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        req0_valid = v.v0; req0_data = v.d0; req0_shift = v.s0; req0_left = v.l0;
        req1_valid = v.v1; req1_data = v.d1; req1_shift = v.s1; req1_left = v.l1;
        out_ready  = (v.stall == 0);
        #1;
        k = 0;
        while (!(req0_ready | req1_ready) && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_grant_wait"}, k, 0);
        chk({tag, "_grant"}, {30'd0, req1_ready, req0_ready}, v.exp_id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        if (v.exp_id) req1_valid = 1'b0;
        else          req0_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_exec_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_exec_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_resp_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_resp_data"}, out_data, v.exp_data);
        chk({tag, "_resp_id"}, {31'd0, out_id}, {31'd0, v.exp_id});
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_data"}, out_data, v.exp_data);
            chk({tag, "_hold_id"}, {31'd0, out_id}, {31'd0, v.exp_id});
            chk({tag, "_hold_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        out_ready = 1'b1;
    endtask

    vec_t tbl[11];
    vec_t rv;
    logic mprio;
    logic [1:0] vsel;

    initial begin
        tbl[0]  = '{1'b1, 32'h80000001, 5'd1,  1'b1, 1'b1, 32'h12345678, 5'd4, 1'b0, 1'b0, 32'h00000003, 0};
        tbl[1]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 32'h12345678, 5'd4, 1'b0, 1'b1, 32'h81234567, 0};
        tbl[2]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 32'h12345678, 5'd0, 1'b0, 1'b1, 32'h12345678, 0};
        tbl[3]  = '{1'b1, 32'h00000001, 5'd31, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 32'h00000002, 0};
        tbl[4]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 32'hF0000000, 5'd31, 1'b1, 1'b1, 32'h78000000, 0};
        tbl[5]  = '{1'b1, 32'h12345678, 5'd16, 1'b1, 1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b0, 32'h56781234, 0};
        tbl[6]  = '{1'b1, 32'h12345678, 5'd16, 1'b1, 1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b1, 32'h0000000F, 0};
        tbl[7]  = '{1'b1, 32'h12345678, 5'd16, 1'b1, 1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b0, 32'h56781234, 0};
        tbl[8]  = '{1'b1, 32'h12345678, 5'd16, 1'b1, 1'b1, 32'h000000F0, 5'd4, 1'b0, 1'b1, 32'h0000000F, 0};
        tbl[9]  = '{1'b1, 32'hDEADBEEF, 5'd8,  1'b1, 1'b1, 32'h00000001, 5'd1, 1'b1, 1'b0, 32'hADBEEFDE, 5};
        tbl[10] = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 32'h00000001, 5'd1, 1'b1, 1'b1, 32'h00000002, 0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 32'hCAFEF00D; req0_shift = 5'd3; req0_left = 1'b1;
        req1_valid = 1'b1; req1_data = 32'h0BADC0DE; req1_shift = 5'd7; req1_left = 1'b0;
        out_ready  = 1'b0;

        // Reset held two cycles with both requesters asserting valid.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_out_id", {31'd0, out_id}, 32'd0);
            chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while the request is in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'hA5A5A5A5; req0_shift = 5'd4; req0_left = 1'b1;
        req1_valid = 1'b0;
        #1;
        chk("mid_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'd0, out_valid}, 32'd0);
            chk("mid_out_data", out_data, 32'd0);
            chk("mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        // Reset returned the tie-break pointer to requester 0.
        rv = '{1'b1, 32'h0000FFFF, 5'd8, 1'b0, 1'b1, 32'h11111111, 5'd2, 1'b1, 1'b0, 32'hFF0000FF, 0};
        run_txn(rv, "post_rst");

        mprio = 1'b1;
        for (int it = 0; it < 30; it++) begin
            vsel = 2'($urandom_range(1, 3));
            rv.v0 = vsel[0];
            rv.v1 = vsel[1];
            rv.d0 = $urandom;
            rv.d1 = $urandom;
            rv.s0 = 5'($urandom_range(0, 31));
            rv.s1 = 5'($urandom_range(0, 31));
            rv.l0 = 1'($urandom_range(0, 1));
            rv.l1 = 1'($urandom_range(0, 1));
            rv.exp_id = (rv.v0 && rv.v1) ? mprio : rv.v1;
            rv.exp_data = rv.exp_id ? ref_rot(rv.d1, int'(rv.s1), rv.l1)
                                    : ref_rot(rv.d0, int'(rv.s0), rv.l0);
            rv.stall = $urandom_range(0, 3);
            mprio = ~rv.exp_id;
            run_txn(rv, $sformatf("rnd%0d", it));
        end

        @(negedge clk);
        chk("final_idle", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
